// File: rtl/acc_requant.sv
// acc_requant: drains int32 accumulators, requantizes them to int8 and
// optionally packs four results per 32-bit word for the CPU.
module acc_requant #(
  parameter int LATENCY_STAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_acc,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_count,
  output logic        busy
);

  typedef struct packed {
    logic [4:0] shift;
    logic [8:0] off;
    logic [7:0] amin;
    logic [7:0] amax;
    logic       pack;
    logic       last;
  } tail_t;

  localparam logic [31:0] MinInt = 32'h8000_0000;

  logic [31:0] bias_q;
  logic [31:0] mult_q;
  logic [4:0]  shift_q;
  logic [8:0]  off_q;
  logic [7:0]  amin_q;
  logic [7:0]  amax_q;
  logic        pack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q  <= '0;
      mult_q  <= '0;
      shift_q <= '0;
      off_q   <= '0;
      amin_q  <= 8'h80;
      amax_q  <= 8'h7f;
      pack_q  <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    bias_q  <= cfg_wdata;
        3'd1:    mult_q  <= cfg_wdata;
        3'd2:    shift_q <= cfg_wdata[4:0];
        3'd3:    off_q   <= cfg_wdata[8:0];
        3'd4:    amin_q  <= cfg_wdata[7:0];
        3'd5:    amax_q  <= cfg_wdata[7:0];
        3'd6:    pack_q  <= cfg_wdata[0];
        default: ;
      endcase
    end
  end

  logic [LATENCY_STAGES-1:0] vld_q;

  logic [31:0] x1_q;
  logic [31:0] m1_q;
  tail_t       t1_q;
  logic [31:0] x1_d;
  tail_t       t1_d;

  logic signed [63:0] p2_q;
  logic               sat2_q;
  tail_t              t2_q;
  logic signed [63:0] xs2;
  logic signed [63:0] ms2;
  logic signed [63:0] p2_d;
  logic               sat2_d;

  logic [7:0] q3_q;
  logic       pack3_q;
  logic       last3_q;
  logic [7:0] q3_d;

  logic adv;
  logic can_load;
  logic conflict;

  // S1: bias add and config snapshot
  assign x1_d = in_acc + bias_q;
  assign t1_d = '{shift: shift_q, off: off_q, amin: amin_q,
                  amax: amax_q, pack: pack_q, last: in_last};

  // S2: full-width product plus the single overflow case
  assign xs2    = {{32{x1_q[31]}}, x1_q};
  assign ms2    = {{32{m1_q[31]}}, m1_q};
  assign p2_d   = xs2 * ms2;
  assign sat2_d = (x1_q == MinInt) && (m1_q == MinInt);

  // S3: rounding high-mul, rounding shift, offset, clamp
  logic signed [63:0] nudge3;
  logic signed [63:0] sum3;
  logic signed [63:0] adj3;
  logic signed [31:0] h3;
  logic signed [31:0] sh3;
  logic signed [31:0] r3;
  logic [31:0]        mask3;
  logic [31:0]        rem3;
  logic [31:0]        thr3;
  logic               rnd3;
  logic signed [32:0] y3;
  logic signed [32:0] lo3;
  logic signed [32:0] hi3;
  logic signed [32:0] c3;
  logic               unused_bits;

  assign nudge3 = p2_q[63] ? -64'sd1073741823 : 64'sd1073741824;
  assign sum3   = p2_q + nudge3;
  assign adj3   = sum3[63] ? sum3 + 64'sd2147483647 : sum3;
  assign h3     = sat2_q ? 32'sh7fff_ffff : adj3[62:31];
  assign mask3  = (32'd1 << t2_q.shift) - 32'd1;
  assign rem3   = h3 & mask3;
  assign thr3   = {1'b0, mask3[31:1]} + {31'd0, h3[31]};
  assign rnd3   = rem3 > thr3;
  assign sh3    = h3 >>> t2_q.shift;
  assign r3     = sh3 + $signed({31'd0, rnd3});
  assign y3     = {r3[31], r3} + {{24{t2_q.off[8]}}, t2_q.off};
  assign lo3    = {{25{t2_q.amin[7]}}, t2_q.amin};
  assign hi3    = {{25{t2_q.amax[7]}}, t2_q.amax};

  always_comb begin
    c3 = y3;
    if (c3 < lo3) c3 = lo3;
    if (c3 > hi3) c3 = hi3;
  end

  assign q3_d = c3[7:0];
  assign unused_bits = ^{adj3[63], adj3[30:0], c3[32:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[LATENCY_STAGES-2:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x1_q    <= x1_d;
      m1_q    <= mult_q;
      t1_q    <= t1_d;
      p2_q    <= p2_d;
      sat2_q  <= sat2_d;
      t2_q    <= t1_q;
      q3_q    <= q3_d;
      pack3_q <= t2_q.pack;
      last3_q <= t2_q.last;
    end
  end

  // Packer and output register
  logic        out_valid_q;
  logic        out_valid_d;
  logic [31:0] out_data_q;
  logic [31:0] out_data_d;
  logic [2:0]  out_count_q;
  logic [2:0]  out_count_d;
  logic [31:0] buf_q;
  logic [31:0] buf_d;
  logic [1:0]  bcnt_q;
  logic [1:0]  bcnt_d;
  logic [31:0] merged;
  logic        s3_vld;

  assign s3_vld   = vld_q[LATENCY_STAGES-1];
  assign can_load = !out_valid_q || out_ready;
  // an unpacked element must wait one slot while a partial word drains
  assign conflict = s3_vld && !pack3_q && (bcnt_q != 2'd0);
  assign adv      = can_load && !conflict;
  assign merged   = buf_q | ({24'd0, q3_q} << {bcnt_q, 3'b000});

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    buf_d       = buf_q;
    bcnt_d      = bcnt_q;
    if (can_load && s3_vld) begin
      if (!pack3_q && bcnt_q != 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = buf_q;
        out_count_d = {1'b0, bcnt_q};
        buf_d       = '0;
        bcnt_d      = '0;
      end else if (!pack3_q) begin
        out_valid_d = 1'b1;
        out_data_d  = {{24{q3_q[7]}}, q3_q};
        out_count_d = 3'd1;
      end else if (bcnt_q == 2'd3 || last3_q) begin
        out_valid_d = 1'b1;
        out_data_d  = merged;
        out_count_d = {1'b0, bcnt_q} + 3'd1;
        buf_d       = '0;
        bcnt_d      = '0;
      end else begin
        buf_d  = merged;
        bcnt_d = bcnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      buf_q       <= '0;
      bcnt_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      buf_q       <= buf_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign busy      = (|vld_q) || (bcnt_q != 2'd0) || out_valid_q;

endmodule

// File: tb/tb_acc_requant.sv
// Bench for acc_requant: directed checks plus randomized streams
// scored against a queue-based arithmetic reference.
module tb_acc_requant;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_acc;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        busy;

  always #5 clk = ~clk;

  acc_requant #(.LATENCY_STAGES(3)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  typedef logic [34:0] word_t;
  word_t got[$];
  word_t exp_q[$];
  word_t seen[$];
  int    pbuf[$];

  int n_cmp = 0;
  int n_err = 0;

  int m_bias, m_mult, m_shift, m_off, m_min, m_max;
  bit m_pack;
  bit sending;

  always @(negedge clk)
    if (!reset && out_valid && out_ready)
      got.push_back({out_count, out_data});

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_bias = 0; m_mult = 0; m_shift = 0; m_off = 0;
    m_min = -128; m_max = 127; m_pack = 0;
    pbuf.delete();
  endtask

  // Requantized int8 value from plain integer arithmetic
  function automatic int model_q(input int acc);
    int x;
    longint p, h, r, y, d, half;
    x = acc + m_bias;
    if (x == int'(32'h8000_0000) && m_mult == int'(32'h8000_0000)) begin
      h = 64'sd2147483647;
    end else begin
      p = longint'(x) * longint'(m_mult);
      if (p >= 0) h = (p + (64'sd1 <<< 30)) / (64'sd1 <<< 31);
      else        h = (p + 1 - (64'sd1 <<< 30)) / (64'sd1 <<< 31);
    end
    if (m_shift == 0) begin
      r = h;
    end else begin
      d = 64'sd1 <<< m_shift;
      half = d / 2;
      if (h >= 0) r = (h + half) / d;
      else        r = -((-h + half) / d);
    end
    y = r + m_off;
    if (y < m_min) y = m_min;
    if (y > m_max) y = m_max;
    return int'(y);
  endfunction

  task automatic flush_pbuf();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < pbuf.size(); i++)
      w = w | (32'(pbuf[i] & 255) << (8 * i));
    exp_q.push_back({3'(pbuf.size()), w});
    pbuf.delete();
  endtask

  task automatic model_push(input int q, input bit last);
    if (!m_pack) begin
      if (pbuf.size() != 0) flush_pbuf();
      exp_q.push_back({3'd1, 32'(q)});
    end else begin
      pbuf.push_back(q & 255);
      if (pbuf.size() == 4 || last) flush_pbuf();
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    case (a)
      3'd0: m_bias = int'(d);
      3'd1: m_mult = int'(d);
      3'd2: m_shift = int'(d[4:0]);
      3'd3: m_off = d[8] ? int'(d[8:0]) - 512 : int'(d[8:0]);
      3'd4: m_min = d[7] ? int'(d[7:0]) - 256 : int'(d[7:0]);
      3'd5: m_max = d[7] ? int'(d[7:0]) - 256 : int'(d[7:0]);
      3'd6: m_pack = d[0];
      default: ;
    endcase
  endtask

  task automatic set_cfg(input int bias, input int mult, input int sh,
                         input int off, input int amin, input int amax,
                         input bit pk);
    cfg_write(3'd0, bias);
    cfg_write(3'd1, mult);
    cfg_write(3'd2, sh);
    cfg_write(3'd3, off & 'h1ff);
    cfg_write(3'd4, amin & 'hff);
    cfg_write(3'd5, amax & 'hff);
    cfg_write(3'd6, {31'd0, pk});
  endtask

  task automatic send(input int acc, input bit last);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_acc = acc; in_last = last;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_push(model_q(acc), last);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (got.size() >= exp_q.size() && !busy) break;
    end
    chk("out_word_count", got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("out_word", got[i], exp_q[i]);
    seen = got;
    got.delete();
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    bit pat[4];
    int mark_e, mark_g;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_acc = '0; in_last = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // basic requant and 3-cycle latency
    set_cfg(0, 32'h4000_0000, 2, -128, -128, 127, 0);
    send(100, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("latency_early", out_valid, 0);
    end
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("basic_data", out_data, 32'hFFFF_FF8D);
    chk("basic_count", out_count, 1);
    @(posedge clk); #1;
    drain();

    set_cfg(0, 32'h7FFF_FFFF, 2, 0, -128, 127, 0);
    send(-6, 0);
    drain();
    chk("neg_round", seen[0], {3'd1, 32'hFFFF_FFFE});

    set_cfg(0, 32'h8000_0000, 0, 0, -128, 127, 0);
    send(32'h8000_0000, 0);
    drain();
    chk("saturate", seen[0], {3'd1, 32'h0000_007F});

    // packing: full word then partial on in_last
    set_cfg(0, 32'h7FFF_FFFF, 0, 0, -128, 127, 1);
    for (int i = 1; i <= 4; i++) send(i, 0);
    send(5, 0);
    send(6, 1);
    drain();
    chk("pack_full", seen[0], {3'd4, 32'h0403_0201});
    chk("pack_partial", seen[1], {3'd2, 32'h0000_0605});

    // backpressure with out_ready pattern 1,0,0,1
    set_cfg(0, 32'h7FFF_FFFF, 0, 0, -128, 127, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) send(10 + i, 0);
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          out_ready = pat[i % 4];
          @(negedge clk);
          if (out_valid && !out_ready)
            chk("stall_in_ready", in_ready, 0);
        end
      end
    join
    drain();
    chk("bp_first", seen[0], {3'd1, 32'd10});
    chk("bp_last", seen[7], {3'd1, 32'd17});

    // per-element config snapshot
    out_ready = 1'b0;
    send(40, 0);
    cfg_write(3'd2, 32'd3);
    send(40, 0);
    drain();
    chk("snap_shift0", seen[0], {3'd1, 32'd40});
    chk("snap_shift3", seen[1], {3'd1, 32'd5});

    // reset with two elements in flight
    set_cfg(0, 32'h7FFF_FFFF, 0, 0, -128, 127, 0);
    mark_e = exp_q.size();
    send(1, 0);
    send(2, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_flight_valid", out_valid, 0);
    chk("rst_flight_busy", busy, 0);
    while (exp_q.size() > mark_e) void'(exp_q.pop_back());
    model_reset();
    mark_g = got.size();
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale", got.size(), mark_g);
    set_cfg(0, 32'h7FFF_FFFF, 0, 0, -128, 127, 0);
    send(-3, 0);
    drain();
    chk("post_reset", seen[0], {3'd1, 32'hFFFF_FFFD});

    // randomized streams with random backpressure and pack toggling
    for (int rnd = 0; rnd < 4; rnd++) begin
      set_cfg(int'($urandom_range(200, 0)) - 100,
              ($urandom_range(1, 0) != 0) ? int'($urandom) : 32'h7FFF_FFFF,
              int'($urandom_range(31, 0)) % ((rnd % 2 != 0) ? 32 : 4),
              int'($urandom_range(511, 0)) - 256,
              int'($urandom_range(255, 0)) - 128,
              int'($urandom_range(255, 0)) - 128,
              bit'($urandom_range(1, 0)));
      sending = 1'b1;
      fork
        begin
          for (int i = 0; i < 30; i++) begin
            if (i % 7 == 6) cfg_write(3'd6, {31'd0, !m_pack});
            send(($urandom_range(1, 0) != 0) ? int'($urandom)
                   : int'($urandom_range(4000, 0)) - 2000,
                 (i == 29) || ($urandom_range(3, 0) == 0));
          end
          sending = 1'b0;
        end
        begin
          for (int i = 0; i < 2000 && sending; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(1, 0) != 0);
          end
        end
      join
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
